muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; only 64 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only while busy=0.
REQ-005 SHALL have port a  input  64  first operand: multiplicand or dividend.
REQ-006 SHALL have port b  input  64  second operand: multiplier or divisor.
REQ-007 SHALL have port func  input  3  RV64M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have port sel_32b  input  1  word (W) variant select, same meaning as the ALU's 32-bit select.
REQ-009 SHALL have port busy  output  1  high from the cycle after accept until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse; s is valid in that cycle.
REQ-011 SHALL have port s  output  64  result; holds its value until the next done.

Function
REQ-012 Accept: start=1 and busy=0 at edge N latches a, b, func and sel_32b; the unit ignores inputs after edge N.
REQ-013 start while busy=1 SHALL be ignored, with no queueing.
REQ-014 States SHALL be IDLE, CHECK, ITER, FIX, DONE.
REQ-015 IDLE->CHECK on accept; CHECK->ITER normally; CHECK->DONE on a division special case; ITER->FIX after the last iteration; FIX->DONE; DONE->IDLE.
REQ-016 CHECK (cycle N+1) SHALL take operand magnitudes and record the result sign.
REQ-017 For W ops, CHECK SHALL first sign-extend bits [31:0] (signed ops) or zero-extend them (unsigned ops).
REQ-018 ITER SHALL perform one radix-2 step per cycle: 64 steps for 64-bit ops, 32 steps for W ops.
REQ-019 Multiply ITER SHALL be shift-add of magnitudes into a 128-bit product.
REQ-020 Divide ITER SHALL be restoring division of magnitudes.
REQ-021 FIX SHALL apply the two's-complement sign correction and select the result.
REQ-022 Multiply result SHALL be: MUL = product[63:0]; MULH/MULHSU/MULHU = product[127:64], with signed x signed, signed x unsigned and unsigned x unsigned operands respectively.
REQ-023 Division result sign rules: quotient negative iff operand signs differ (signed ops); remainder takes the dividend's sign.
REQ-024 Timing SHALL be fixed: done at cycle N+67 for 64-bit ops and N+35 for W ops, measured as edge count after accept.
REQ-025 Divide by zero (b=0 after extension), detected in CHECK: quotient = all ones; remainder = dividend; done at N+3.
REQ-026 Signed overflow (dividend = most-negative, divisor = -1), detected in CHECK: quotient = dividend; remainder = 0; done at N+3.
REQ-027 sel_32b=1 SHALL sign-extend s from bit 31.
REQ-028 sel_32b=1 with func 001/010/011 SHALL behave as MULW.
REQ-029 done SHALL be high only in state DONE.
REQ-030 busy SHALL be high in CHECK, ITER and FIX, and low in IDLE and DONE.
REQ-031 A new start in the DONE cycle SHALL be accepted, giving back-to-back operation.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, s=0, and clear the iteration counter and all working registers.
REQ-033 Reset mid-operation SHALL abort the operation with no done pulse.
REQ-034 After reset release the first accept SHALL behave identically to a cold start.

Structure
REQ-035 A shared package SHALL hold the func encodings (MUL..REMU), the state enum and the iteration counts 64 and 32.
REQ-036 One sub-module, muldiv_step, SHALL be the combinational single-iteration datapath (add/shift or trial-subtract).
REQ-037 The FSM, counter and registers SHALL reside in muldiv_unit.

Verification
REQ-038 Bench SHALL cover MUL: a=3, b=0xFFFFFFFFFFFFFFFB (-5) -> s=0xFFFFFFFFFFFFFFF1, done at N+67, busy high N+1..N+66.
REQ-039 Bench SHALL cover MULHU: a=b=0xFFFFFFFFFFFFFFFF -> s=0xFFFFFFFFFFFFFFFE.
REQ-040 Bench SHALL cover MULH on the same operands -> s=0.
REQ-041 Bench SHALL cover DIV: a=7, b=0 -> s=0xFFFFFFFFFFFFFFFF at N+3.
REQ-042 Bench SHALL cover REM: a=7, b=0 -> s=7 at N+3.
REQ-043 Bench SHALL cover DIV: a=0x8000000000000000, b=-1 -> s=0x8000000000000000.
REQ-044 Bench SHALL cover REM on the same operands -> s=0.
REQ-045 Bench SHALL cover DIVW: a=0x00000000FFFFFFF9, b=2 -> s=0xFFFFFFFFFFFFFFFD at N+35.
REQ-046 Bench SHALL cover REMW on the same operands -> s=0xFFFFFFFFFFFFFFFF.
REQ-047 Bench SHALL cover start held high throughout a DIVU 100/7: only one operation runs; s=14; a second start in the DONE cycle is accepted.
REQ-048 Bench SHALL cover rst_n pulsed low at N+20 of a MUL: no done pulse; busy=0 and s=0 during reset; a subsequent MUL 6*7 gives s=42.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit.
package muldiv_unit_pkg;

  localparam int unsigned XLEN_W  = 64;
  localparam int unsigned ACC_W   = 2 * XLEN_W;
  localparam int unsigned ITER_64 = 64;
  localparam int unsigned ITER_32 = 32;
  localparam int unsigned CNT_W   = 7;

  typedef enum logic [2:0] {
    F_MUL    = 3'b000,
    F_MULH   = 3'b001,
    F_MULHSU = 3'b010,
    F_MULHU  = 3'b011,
    F_DIV    = 3'b100,
    F_DIVU   = 3'b101,
    F_REM    = 3'b110,
    F_REMU   = 3'b111
  } func_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ITER  = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Operation captured at accept time.
  typedef struct packed {
    func_e              func;
    logic               w;
    logic [XLEN_W-1:0]  a;
    logic [XLEN_W-1:0]  b;
  } op_t;

  function automatic logic [XLEN_W-1:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step.
module muldiv_step
  import muldiv_unit_pkg::*;
(
  input  logic             is_div,
  input  logic [ACC_W-1:0] acc,
  input  logic [XLEN_W-1:0] opnd,
  output logic [ACC_W-1:0] acc_next_c
);

  logic [XLEN_W:0]   sum_c;
  logic [XLEN_W:0]   rem_sh_c;
  logic [XLEN_W-1:0] diff_c;
  logic              ge_c;

  always_comb begin
    sum_c    = {1'b0, acc[ACC_W-1:XLEN_W]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh_c = acc[ACC_W-1:XLEN_W-1];
    ge_c     = (rem_sh_c >= {1'b0, opnd});
    diff_c   = rem_sh_c[XLEN_W-1:0] - opnd;
    if (is_div) begin
      // Partial remainder is always below the divisor, so it fits back in 64 bits.
      if (ge_c) acc_next_c = {diff_c, acc[XLEN_W-2:0], 1'b1};
      else      acc_next_c = {rem_sh_c[XLEN_W-1:0], acc[XLEN_W-2:0], 1'b0};
    end else begin
      acc_next_c = {sum_c, acc[XLEN_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: sign handling around an unsigned
// radix-2 core, fixed latency independent of operand values.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      func,
  input  logic            sel_32b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] s
);

  state_e              state_q, state_d;
  op_t                 op_q, op_d;
  logic [XLEN_W-1:0]   dm_q, dm_d;
  logic [ACC_W-1:0]    acc_q, acc_d, step_c;
  logic                neg_q, neg_d;
  logic                special_q, special_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN_W-1:0]   s_d;
  logic                busy_d, done_d;

  logic                is_div_c, mul_w_c, a_sgn_c, b_sgn_c;
  logic                neg_a_c, neg_b_c, res_neg_c, div_zero_c, div_ovf_c;
  logic [XLEN_W-1:0]   xa_c, xb_c, ma_c, mb_c, spec_c;
  logic [XLEN_W-1:0]   quo_c, rmd_c, raw_c, fix_c;
  logic [ACC_W-1:0]    mul_p_c;
  logic                accept_c;

  muldiv_step u_step (
    .is_div     (is_div_c),
    .acc        (acc_q),
    .opnd       (dm_q),
    .acc_next_c (step_c)
  );

  // Operand extension, magnitudes, special-case detection and result fix-up.
  always_comb begin
    is_div_c   = op_q.func[2];
    mul_w_c    = !is_div_c && op_q.w;
    a_sgn_c    = !mul_w_c && (op_q.func inside {F_MULH, F_MULHSU, F_DIV, F_REM});
    b_sgn_c    = !mul_w_c && (op_q.func inside {F_MULH, F_DIV, F_REM});
    xa_c       = op_q.w ? (a_sgn_c ? sext32(op_q.a[31:0]) : {32'd0, op_q.a[31:0]}) : op_q.a;
    xb_c       = op_q.w ? (b_sgn_c ? sext32(op_q.b[31:0]) : {32'd0, op_q.b[31:0]}) : op_q.b;
    neg_a_c    = a_sgn_c && xa_c[XLEN_W-1];
    neg_b_c    = b_sgn_c && xb_c[XLEN_W-1];
    ma_c       = neg_a_c ? -xa_c : xa_c;
    mb_c       = neg_b_c ? -xb_c : xb_c;
    res_neg_c  = (is_div_c && op_q.func[1]) ? neg_a_c : (neg_a_c ^ neg_b_c);
    div_zero_c = is_div_c && (xb_c == '0);
    div_ovf_c  = is_div_c && b_sgn_c && (xb_c == '1) &&
                 (xa_c == (op_q.w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    spec_c     = op_q.func[1] ? (div_zero_c ? xa_c : '0) : (div_zero_c ? '1 : xa_c);

    // A 32-step multiply leaves the product 32 bits up in the accumulator.
    mul_p_c = op_q.w ? {32'd0, acc_q[ACC_W-1:32]} : acc_q;
    if (neg_q) mul_p_c = -mul_p_c;
    quo_c = neg_q ? -acc_q[XLEN_W-1:0] : acc_q[XLEN_W-1:0];
    rmd_c = neg_q ? -acc_q[ACC_W-1:XLEN_W] : acc_q[ACC_W-1:XLEN_W];
    if (is_div_c) raw_c = op_q.func[1] ? rmd_c : quo_c;
    else          raw_c = (op_q.func == F_MUL || op_q.w) ? mul_p_c[XLEN_W-1:0]
                                                         : mul_p_c[ACC_W-1:XLEN_W];
    fix_c = op_q.w ? sext32(raw_c[31:0]) : raw_c;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dm_d      = dm_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    special_d = special_q;
    cnt_d     = cnt_q;
    s_d       = s;
    accept_c  = start && (state_q == S_IDLE || state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CHECK;
      end
      S_CHECK: begin
        // Special divides spend a second cycle in CHECK holding the final value.
        if (special_q) begin
          state_d   = S_DONE;
          special_d = 1'b0;
          s_d       = op_q.w ? sext32(acc_q[31:0]) : acc_q[XLEN_W-1:0];
        end else if (div_zero_c || div_ovf_c) begin
          special_d = 1'b1;
          acc_d     = {{XLEN_W{1'b0}}, spec_c};
        end else begin
          state_d = S_ITER;
          dm_d    = is_div_c ? mb_c : ma_c;
          if (is_div_c)
            acc_d = {{XLEN_W{1'b0}}, (op_q.w ? {ma_c[31:0], 32'd0} : ma_c)};
          else
            acc_d = {{XLEN_W{1'b0}}, mb_c};
          neg_d = res_neg_c;
          cnt_d = op_q.w ? CNT_W'(ITER_32) : CNT_W'(ITER_64);
        end
      end
      S_ITER: begin
        acc_d = step_c;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        s_d     = fix_c;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = start ? S_CHECK : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept_c) begin
      op_d.func = func_e'(func);
      op_d.w    = sel_32b;
      op_d.a    = a;
      op_d.b    = b;
      special_d = 1'b0;
    end

    busy_d = (state_d == S_CHECK) || (state_d == S_ITER) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      dm_q      <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      cnt_q     <= '0;
      s         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dm_q      <= dm_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      cnt_q     <= cnt_d;
      s         <= s_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// operations checked against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] a;
  logic [63:0] b;
  logic [2:0]  func;
  logic        sel_32b;
  logic        busy;
  logic        done;
  logic [63:0] s;

  int vectors;
  int miscompares;

  muldiv_unit #(.XLEN(64)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .func    (func),
    .sel_32b (sel_32b),
    .busy    (busy),
    .done    (done),
    .s       (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: RV64M semantics using native arithmetic on the full-width values.
  function automatic logic [63:0] ref_model(input logic [2:0] f, input logic w,
                                            input logic [63:0] av, input logic [63:0] bv);
    logic signed [31:0] xs, ys;
    logic [31:0]        xu, yu, r32;
    logic signed [63:0] xl, yl;
    logic [63:0]        ul, vl, r64;
    logic [127:0]       ea, eb, p;
    if (w) begin
      xs = av[31:0]; ys = bv[31:0]; xu = av[31:0]; yu = bv[31:0];
      case (f)
        3'b100:  r32 = (yu == 0) ? 32'hFFFF_FFFF : (xu == 32'h8000_0000 && yu == 32'hFFFF_FFFF) ? xu : 32'(xs / ys);
        3'b101:  r32 = (yu == 0) ? 32'hFFFF_FFFF : xu / yu;
        3'b110:  r32 = (yu == 0) ? xu : (xu == 32'h8000_0000 && yu == 32'hFFFF_FFFF) ? 32'd0 : 32'(xs % ys);
        3'b111:  r32 = (yu == 0) ? xu : xu % yu;
        default: r32 = xu * yu;
      endcase
      return {{32{r32[31]}}, r32};
    end
    xl = av; yl = bv; ul = av; vl = bv;
    ea = (f == 3'b001 || f == 3'b010) ? {{64{av[63]}}, av} : {64'd0, av};
    eb = (f == 3'b001) ? {{64{bv[63]}}, bv} : {64'd0, bv};
    p  = ea * eb;
    case (f)
      3'b000:  r64 = p[63:0];
      3'b100:  r64 = (vl == 0) ? '1 : (ul == 64'h8000_0000_0000_0000 && vl == '1) ? ul : 64'(xl / yl);
      3'b101:  r64 = (vl == 0) ? '1 : ul / vl;
      3'b110:  r64 = (vl == 0) ? ul : (ul == 64'h8000_0000_0000_0000 && vl == '1) ? 64'd0 : 64'(xl % yl);
      3'b111:  r64 = (vl == 0) ? ul : ul % vl;
      default: r64 = p[127:64];
    endcase
    return r64;
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic w,
                                 input logic [63:0] av, input logic [63:0] bv);
    logic zero, ovf;
    zero = w ? (bv[31:0] == 32'd0) : (bv == 64'd0);
    ovf  = (f == 3'b100 || f == 3'b110) &&
           (w ? (av[31:0] == 32'h8000_0000 && bv[31:0] == 32'hFFFF_FFFF)
              : (av == 64'h8000_0000_0000_0000 && bv == '1));
    if (f[2] && (zero || ovf)) return 3;
    return w ? 35 : 67;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0:       v = 64'd0;
      1:       v = 64'd1;
      2:       v = '1;
      3:       v = 64'h8000_0000_0000_0000;
      4:       v = 64'($urandom_range(0, 20));
      5:       v = {32'($urandom), 32'h8000_0000};
      6:       v = {32'($urandom), 32'hFFFF_FFFF};
      default: v = {32'($urandom), 32'($urandom)};
    endcase
    return v;
  endfunction

  // Present one request; returns just after the accept edge with inputs scrambled.
  task automatic issue(input logic [2:0] f, input logic w, input logic [63:0] av, input logic [63:0] bv);
    @(negedge clk);
    start = 1'b1; func = f; sel_32b = w; a = av; b = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = {32'($urandom), 32'($urandom)};
    b = {32'($urandom), 32'($urandom)};
    func = 3'($urandom);
    sel_32b = 1'($urandom);
  endtask

  // Follow an accepted operation cycle by cycle; ends at the negedge of the done cycle.
  task automatic track(input logic [63:0] exp, input int lat, input string tag);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      vectors++;
      if (c < lat) begin
        assert (busy === 1'b1 && done === 1'b0) else begin
          miscompares++;
          $error("FAIL %s busy/done at cycle %0d: got busy=%b done=%b, want busy=1 done=0", tag, c, busy, done);
        end
      end else begin
        assert (done === 1'b1 && busy === 1'b0 && s === exp) else begin
          miscompares++;
          $error("FAIL %s result at cycle %0d: got done=%b busy=%b s=%h, want done=1 busy=0 s=%h",
                 tag, c, done, busy, s, exp);
        end
      end
    end
  endtask

  task automatic run(input logic [2:0] f, input logic w, input logic [63:0] av, input logic [63:0] bv,
                     input logic [63:0] exp, input int lat, input string tag);
    issue(f, w, av, bv);
    track(exp, lat, tag);
  endtask

  initial begin
    logic [63:0] ra, rb, rexp;
    logic [2:0]  rf;
    logic        rw;
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; func = '0; sel_32b = 1'b0;

    repeat (2) @(negedge clk);
    vectors++;
    assert (busy === 1'b0 && done === 1'b0 && s === 64'd0) else begin
      miscompares++;
      $error("FAIL reset_state: got busy=%b done=%b s=%h, want 0 0 0", busy, done, s);
    end
    rst_n = 1'b1;

    run(3'b000, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 67, "mul_3x-5");
    @(negedge clk);
    vectors++;
    assert (done === 1'b0 && busy === 1'b0 && s === 64'hFFFF_FFFF_FFFF_FFF1) else begin
      miscompares++;
      $error("FAIL mul_hold: got done=%b busy=%b s=%h, want 0 0 fffffffffffffff1", done, busy, s);
    end

    run(3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 67, "mulhu_ones");
    run(3'b001, 1'b0, '1, '1, 64'd0, 67, "mulh_ones");
    run(3'b100, 1'b0, 64'd7, 64'd0, '1, 3, "div_by_zero");
    run(3'b110, 1'b0, 64'd7, 64'd0, 64'd7, 3, "rem_by_zero");
    run(3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 3, "div_ovf");
    run(3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 3, "rem_ovf");
    run(3'b100, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 35, "divw");
    run(3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, '1, 35, "remw");
    run(3'b011, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0003,
        ref_model(3'b000, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0003), 35, "mulhuw_as_mulw");

    // Start held high through a whole DIVU, then accepted again from the done cycle.
    @(negedge clk);
    start = 1'b1; func = 3'b101; sel_32b = 1'b0; a = 64'd100; b = 64'd7;
    @(posedge clk);
    track(64'd14, 67, "divu_hold");
    @(posedge clk);
    #1;
    start = 1'b0;
    track(64'd14, 67, "divu_b2b");

    // Reset in the middle of a multiply.
    issue(3'b000, 1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    assert (busy === 1'b0 && done === 1'b0 && s === 64'd0) else begin
      miscompares++;
      $error("FAIL reset_mid_op: got busy=%b done=%b s=%h, want 0 0 0", busy, done, s);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      vectors++;
      assert (done === 1'b0 && busy === 1'b0) else begin
        miscompares++;
        $error("FAIL reset_abort cycle %0d: got done=%b busy=%b, want 0 0", c, done, busy);
      end
    end
    run(3'b000, 1'b0, 64'd6, 64'd7, 64'd42, 67, "mul_after_reset");

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom); rw = 1'($urandom); ra = pick(); rb = pick();
      rexp = ref_model(rf, rw, ra, rb);
      run(rf, rw, ra, rb, rexp, ref_lat(rf, rw, ra, rb),
          $sformatf("rand%0d_f%0d_w%0d_a%h_b%h", i, rf, rw, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
